rs_seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider for the genesis3 soft-arithmetic library.
- Inverse of the carry-chain adder. Each iteration performs one trial subtraction, expressed as a ripple of p/g/carry cells: p = a XOR NOT b, g = a AND NOT b, carry-in = 1.
- Sits behind a valid/ready handshake on both sides. Used where a hard divider is unavailable and area matters more than latency.

---
 rtl/rs_seq_divider.sv | 115 +++++++++++
 tb/tb_rs_seq_divider.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_seq_divider.sv
// Multi-cycle unsigned restoring divider; one quotient bit per clock through a p/g carry-chain subtractor.
// Latency: WIDTH+1 cycles from accept to out_valid (1 cycle for a zero divisor).
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module rs_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             dbz_q;

    logic [WIDTH:0]   trial, sub_b, p, g;
    logic [WIDTH-1:0] diff;
    logic             cout;

    // Trial subtraction trial - {0,divisor} as trial + ~divisor + 1; carry-out high means no borrow.
    always_comb begin
        logic c;
        trial = {rem_q, quo_q[WIDTH-1]};
        sub_b = {1'b0, dvs_q};
        p     = trial ^ ~sub_b;
        g     = trial & ~sub_b;
        diff  = '0;
        c     = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = p[i] ^ c;
            c       = g[i] | (p[i] & c);
        end
        cout = g[WIDTH] | (p[WIDTH] & c);
    end

    always_ff @(posedge C) begin
        if (R) state <= IDLE;
        else   state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                if (cnt == CW'(1)) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            dbz_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quo_q <= '1;
                            rem_q <= dividend;
                            dbz_q <= 1'b1;
                        end else begin
                            rem_q <= '0;
                            quo_q <= dividend;
                            dvs_q <= divisor;
                            cnt   <= CW'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    // A restored trial always fits in WIDTH bits since it is below the divisor.
                    quo_q <= {quo_q[WIDTH-2:0], cout};
                    rem_q <= cout ? diff : trial[WIDTH-1:0];
                    cnt   <= cnt - CW'(1);
                end
                DONE: begin
                    if (out_ready) dbz_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_rs_seq_divider.sv
// Bench for rs_seq_divider: directed cases at WIDTH 8, then randomized regressions at WIDTH 8 and 16
// checked against plain integer division.
module tb_rs_seq_divider;

    logic        C = 1'b0;
    logic        R = 1'b1;

    logic        iv = 1'b0, ir, ov, ordy = 1'b0, dz;
    logic [7:0]  dd = '0, dv = '0, q, rm;

    logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b0, dz16;
    logic [15:0] dd16 = '0, dv16 = '0, q16, rm16;

    int checks = 0;
    int errors = 0;

    always #5 C = ~C;

    rs_seq_divider #(.WIDTH(8)) dut8 (
        .C(C), .R(R), .in_valid(iv), .in_ready(ir), .dividend(dd), .divisor(dv),
        .out_valid(ov), .out_ready(ordy), .quotient(q), .remainder(rm), .div_by_zero(dz)
    );

    rs_seq_divider #(.WIDTH(16)) dut16 (
        .C(C), .R(R), .in_valid(iv16), .in_ready(ir16), .dividend(dd16), .divisor(dv16),
        .out_valid(ov16), .out_ready(ordy16), .quotient(q16), .remainder(rm16), .div_by_zero(dz16)
    );

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        chk("in_ready_before_accept", 32'(ir), 1);
        iv = 1'b1; dd = a; dv = b;
        tick;
        iv = 1'b0; dd = 8'($urandom); dv = 8'($urandom);
    endtask

    // Returns the cycle (accept edge ends cycle 0) in which out_valid is first seen high.
    task automatic wait8(output int cyc);
        cyc = 1;
        while (!ov && cyc < 200) begin
            chk("in_ready_in_calc", 32'(ir), 0);
            tick;
            cyc++;
        end
    endtask

    task automatic consume8(input logic [7:0] eq, input logic [7:0] er);
        ordy = 1'b1;
        tick;
        ordy = 1'b0;
        chk("in_ready_after_consume", 32'(ir), 1);
        chk("out_valid_after_consume", 32'(ov), 0);
        chk("dbz_after_consume", 32'(dz), 0);
        chk("q_kept_after_consume", 32'(q), 32'(eq));
        chk("r_kept_after_consume", 32'(rm), 32'(er));
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input int elat,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz);
        int cyc;
        start8(a, b);
        wait8(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'(elat));
        chk({tag, "_quotient"}, 32'(q), 32'(eq));
        chk({tag, "_remainder"}, 32'(rm), 32'(er));
        chk({tag, "_dbz"}, 32'(dz), 32'(edz));
        consume8(eq, er);
    endtask

    task automatic rand8(input int n);
        logic [7:0] a, b, eq, er;
        int cyc;
        for (int k = 0; k < n; k++) begin
            a = 8'($urandom);
            if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            case ($urandom_range(0, 7))
                0:       b = 8'h00;
                1:       b = 8'h01;
                2:       b = 8'($urandom_range(1, 15));
                3:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            eq = (b == 0) ? 8'hFF : a / b;
            er = (b == 0) ? a : a % b;
            start8(a, b);
            wait8(cyc);
            chk("r8_latency", 32'(cyc), (b == 0) ? 1 : 9);
            chk("r8_quotient", 32'(q), 32'(eq));
            chk("r8_remainder", 32'(rm), 32'(er));
            chk("r8_dbz", 32'(dz), 32'(b == 0));
            if (b != 0) begin
                chk("r8_invariant", 32'(q) * 32'(b) + 32'(rm), 32'(a));
                chk("r8_rem_lt_div", 32'(rm < b), 1);
            end
            repeat ($urandom_range(0, 3)) begin
                tick;
                chk("r8_stall_q", 32'(q), 32'(eq));
                chk("r8_stall_valid", 32'(ov), 1);
            end
            consume8(eq, er);
            repeat ($urandom_range(0, 1)) tick;
        end
    endtask

    task automatic rand16(input int n);
        logic [15:0] a, b, eq, er;
        int cyc;
        for (int k = 0; k < n; k++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
            case ($urandom_range(0, 7))
                0:       b = 16'h0000;
                1:       b = 16'h0001;
                2:       b = 16'($urandom_range(1, 300));
                3:       b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            eq = (b == 0) ? 16'hFFFF : a / b;
            er = (b == 0) ? a : a % b;
            chk("r16_in_ready", 32'(ir16), 1);
            iv16 = 1'b1; dd16 = a; dv16 = b;
            tick;
            iv16 = 1'b0; dd16 = 16'($urandom); dv16 = 16'($urandom);
            cyc = 1;
            while (!ov16 && cyc < 200) begin
                tick;
                cyc++;
            end
            chk("r16_latency", 32'(cyc), (b == 0) ? 1 : 17);
            chk("r16_quotient", 32'(q16), 32'(eq));
            chk("r16_remainder", 32'(rm16), 32'(er));
            chk("r16_dbz", 32'(dz16), 32'(b == 0));
            if (b != 0) begin
                chk("r16_invariant", 32'(q16) * 32'(b) + 32'(rm16), 32'(a));
                chk("r16_rem_lt_div", 32'(rm16 < b), 1);
            end
            repeat ($urandom_range(0, 3)) begin
                tick;
                chk("r16_stall_r", 32'(rm16), 32'(er));
            end
            ordy16 = 1'b1;
            tick;
            ordy16 = 1'b0;
            chk("r16_idle_after_consume", 32'(ir16), 1);
            chk("r16_dbz_clear", 32'(dz16), 0);
        end
    endtask

    initial begin
        int cyc;

        // Reset
        R = 1'b1;
        tick;
        tick;
        R = 1'b0;
        chk("rst_in_ready", 32'(ir), 1);
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_quotient", 32'(q), 0);
        chk("rst_remainder", 32'(rm), 0);
        chk("rst_dbz", 32'(dz), 0);
        chk("rst16_in_ready", 32'(ir16), 1);
        chk("rst16_out_valid", 32'(ov16), 0);

        // Basic and edge-value divides
        op8("basic_100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
        op8("edge_255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
        op8("edge_5_9", 8'd5, 8'd9, 9, 8'd0, 8'd5, 1'b0);
        op8("edge_0_3", 8'd0, 8'd3, 9, 8'd0, 8'd0, 1'b0);
        op8("edge_255_255", 8'd255, 8'd255, 9, 8'd1, 8'd0, 1'b0);

        // Divide by zero bypasses CALC
        op8("dbz_37_0", 8'd37, 8'd0, 1, 8'd255, 8'd37, 1'b1);

        // Backpressure with a competing in_valid during DONE
        start8(8'd200, 8'd13);
        wait8(cyc);
        chk("bp_latency", 32'(cyc), 9);
        iv = 1'b1; dd = 8'd50; dv = 8'd5;
        repeat (20) begin
            tick;
            chk("bp_quotient", 32'(q), 15);
            chk("bp_remainder", 32'(rm), 5);
            chk("bp_out_valid", 32'(ov), 1);
            chk("bp_in_ready", 32'(ir), 0);
        end
        ordy = 1'b1;
        tick;
        ordy = 1'b0;
        chk("bp_idle_in_ready", 32'(ir), 1);
        chk("bp_idle_out_valid", 32'(ov), 0);
        chk("bp_not_accepted_q", 32'(q), 15);
        iv = 1'b0;
        tick;
        chk("bp_still_idle", 32'(ir), 1);

        // Reset in cycle 4 of an operation
        start8(8'd99, 8'd4);
        tick;
        tick;
        tick;
        R = 1'b1;
        tick;
        R = 1'b0;
        chk("midrst_in_ready", 32'(ir), 1);
        chk("midrst_out_valid", 32'(ov), 0);
        chk("midrst_quotient", 32'(q), 0);
        chk("midrst_remainder", 32'(rm), 0);
        chk("midrst_dbz", 32'(dz), 0);
        repeat (12) begin
            tick;
            chk("midrst_no_stale_result", 32'(ov), 0);
        end
        op8("after_rst_50_5", 8'd50, 8'd5, 9, 8'd10, 8'd0, 1'b0);

        // Randomized regressions
        rand8(1500);
        rand16(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
